clock_field_ctrl: RTL

- Parametrised successor of the clock run/set controller: drives up/down strobes for N cascaded time-field counters.
- Field 0 is the free-running sub-second counter; fields 1..N-1 are user-settable.
- Adds:
  - internal edge detection on left/right;
  - auto-repeat on held up/down;
  - cursor wrap over any field count;
  - a blink strobe for the display of the selected field.
- Sits between the synchronized button block and the field counter chain.

---
 rtl/clock_ctrl_pkg.sv | 15 +
 rtl/clock_field_ctrl_if.sv | 30 +++
 rtl/clock_field_ctrl_btn_repeat.sv | 66 ++++++
 rtl/clock_field_ctrl.sv | 126 ++++++++++++
 4 files changed

// File: rtl/clock_ctrl_pkg.sv
// Shared definitions for the clock field controller: state encoding and parameter defaults.
package clock_ctrl_pkg;

  typedef enum logic {
    C_RUN = 1'b0,
    C_SET = 1'b1
  } state_t;

  localparam int unsigned DEF_N_FIELDS      = 4;
  localparam int unsigned DEF_HOLD_DELAY    = 500;
  localparam int unsigned DEF_REPEAT_PERIOD = 100;
  localparam int unsigned DEF_BLINK_PERIOD  = 250;
  localparam int unsigned DEF_CNT_W         = 16;

endpackage

// File: rtl/clock_field_ctrl_if.sv
// Button, carry and field-strobe signals between the button block, controller and counter chain.
interface clock_field_ctrl_if
  import clock_ctrl_pkg::*;
#(
  parameter int unsigned N_FIELDS = DEF_N_FIELDS
);
  localparam int unsigned CUR_W = $clog2(N_FIELDS);

  logic                i_set;
  logic                i_up;
  logic                i_down;
  logic                i_left;
  logic                i_right;
  logic [N_FIELDS-2:0] i_carryup;
  logic [N_FIELDS-1:0] o_up;
  logic [N_FIELDS-1:0] o_down;
  logic                o_set_mode;
  logic [CUR_W-1:0]    o_cursor;
  logic                o_blink;

  modport master (
    output i_set, i_up, i_down, i_left, i_right, i_carryup,
    input  o_up, o_down, o_set_mode, o_cursor, o_blink
  );

  modport slave (
    input  i_set, i_up, i_down, i_left, i_right, i_carryup,
    output o_up, o_down, o_set_mode, o_cursor, o_blink
  );
endinterface

// File: rtl/clock_field_ctrl_btn_repeat.sv
// Edge-triggered strobe with hold-delay auto-repeat for one up/down button.
module btn_repeat
  import clock_ctrl_pkg::*;
#(
  parameter int unsigned HOLD_DELAY    = DEF_HOLD_DELAY,
  parameter int unsigned REPEAT_PERIOD = DEF_REPEAT_PERIOD,
  parameter int unsigned CNT_W         = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic clear,
  input  logic button,
  input  logic suppress,
  output logic strobe
);

  logic             prev;
  logic             armed;
  logic             repeating;
  logic [CNT_W-1:0] cnt;
  logic             rise;

  assign rise = button & ~prev;

  // armed only after a genuine press, so a button held across SET entry stays silent
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev      <= 1'b0;
      armed     <= 1'b0;
      repeating <= 1'b0;
      cnt       <= '0;
      strobe    <= 1'b0;
    end else begin
      prev   <= button;
      strobe <= 1'b0;
      if (clear || !enable || !button) begin
        armed     <= 1'b0;
        repeating <= 1'b0;
        cnt       <= '0;
      end else if (rise) begin
        strobe    <= 1'b1;
        armed     <= 1'b1;
        repeating <= 1'b0;
        cnt       <= CNT_W'(1);
      end else if (!armed || suppress) begin
        repeating <= 1'b0;
        cnt       <= '0;
      end else if (!repeating) begin
        if (cnt == CNT_W'(HOLD_DELAY)) begin
          strobe    <= 1'b1;
          repeating <= 1'b1;
          cnt       <= CNT_W'(1);
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end else if (cnt == CNT_W'(REPEAT_PERIOD)) begin
        strobe <= 1'b1;
        cnt    <= CNT_W'(1);
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/clock_field_ctrl.sv
// Run/set controller driving up/down strobes for a chain of N_FIELDS cascaded time-field counters.
module clock_field_ctrl
  import clock_ctrl_pkg::*;
#(
  parameter int unsigned N_FIELDS      = DEF_N_FIELDS,
  parameter int unsigned HOLD_DELAY    = DEF_HOLD_DELAY,
  parameter int unsigned REPEAT_PERIOD = DEF_REPEAT_PERIOD,
  parameter int unsigned BLINK_PERIOD  = DEF_BLINK_PERIOD,
  parameter int unsigned CNT_W         = DEF_CNT_W
) (
  input  logic               i_clk,
  input  logic               i_rstn,
  clock_field_ctrl_if.slave  bus
);

  localparam int unsigned      CUR_W   = $clog2(N_FIELDS);
  localparam logic [CUR_W-1:0] CUR_MIN = CUR_W'(1);
  localparam logic [CUR_W-1:0] CUR_MAX = CUR_W'(N_FIELDS - 1);

  state_t              state;
  logic [CUR_W-1:0]    cursor;
  logic                blink;
  logic [CNT_W-1:0]    blink_cnt;
  logic                left_q;
  logic                right_q;
  logic                up_strobe;
  logic                down_strobe;
  logic                in_set;
  logic                mode_change;
  logic                move_left;
  logic                move_right;
  logic                both_held;
  logic [N_FIELDS-1:0] sel;
  logic [N_FIELDS-1:0] up_c;
  logic [N_FIELDS-1:0] down_c;

  assign in_set      = (state == C_SET);
  assign mode_change = in_set ? ~bus.i_set : bus.i_set;
  assign move_left   = (bus.i_left & ~left_q) & ~(bus.i_right & ~right_q);
  assign move_right  = (bus.i_right & ~right_q) & ~(bus.i_left & ~left_q);
  assign both_held   = bus.i_up & bus.i_down;

  btn_repeat #(
    .HOLD_DELAY(HOLD_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD), .CNT_W(CNT_W)
  ) u_up (
    .clk(i_clk), .rst_n(i_rstn), .enable(in_set), .clear(mode_change),
    .button(bus.i_up), .suppress(both_held), .strobe(up_strobe)
  );

  btn_repeat #(
    .HOLD_DELAY(HOLD_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD), .CNT_W(CNT_W)
  ) u_down (
    .clk(i_clk), .rst_n(i_rstn), .enable(in_set), .clear(mode_change),
    .button(bus.i_down), .suppress(both_held), .strobe(down_strobe)
  );

  // mode, cursor and blink phase; any edit restarts blink in the visible phase
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state     <= C_RUN;
      cursor    <= CUR_MIN;
      blink     <= 1'b0;
      blink_cnt <= '0;
      left_q    <= 1'b0;
      right_q   <= 1'b0;
    end else begin
      left_q  <= bus.i_left;
      right_q <= bus.i_right;
      case (state)
        C_RUN: begin
          blink     <= 1'b0;
          blink_cnt <= '0;
          if (bus.i_set) begin
            state  <= C_SET;
            cursor <= CUR_MIN;
          end
        end
        C_SET: begin
          if (!bus.i_set) begin
            state     <= C_RUN;
            blink     <= 1'b0;
            blink_cnt <= '0;
          end else begin
            if (move_left) begin
              cursor <= (cursor == CUR_MAX) ? CUR_MIN : cursor + CUR_W'(1);
            end else if (move_right) begin
              cursor <= (cursor == CUR_MIN) ? CUR_MAX : cursor - CUR_W'(1);
            end
            if (move_left || move_right || up_strobe || down_strobe) begin
              blink     <= 1'b1;
              blink_cnt <= '0;
            end else if (blink_cnt == CNT_W'(BLINK_PERIOD - 1)) begin
              blink     <= ~blink;
              blink_cnt <= '0;
            end else begin
              blink_cnt <= blink_cnt + CNT_W'(1);
            end
          end
        end
        default: state <= C_RUN;
      endcase
    end
  end

  // field strobes: RUN passes carries straight through, SET steers edits to the cursor field
  always_comb begin
    sel    = N_FIELDS'(1) << cursor;
    up_c   = '0;
    down_c = '0;
    if (i_rstn) begin
      if (in_set) begin
        up_c   = up_strobe ? sel : '0;
        down_c = (down_strobe ? sel : '0) | N_FIELDS'(1);
      end else begin
        up_c = {bus.i_carryup, 1'b1};
      end
    end
  end

  assign bus.o_up       = up_c;
  assign bus.o_down     = down_c;
  assign bus.o_set_mode = in_set;
  assign bus.o_cursor   = cursor;
  assign bus.o_blink    = blink;

endmodule
